fetch_ifid_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register for the single-issue 32-bit core.

---
 rtl/fetch_ifid_stage.sv | 92 +++++++++
 tb/tb_fetch_ifid_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_stage.sv
// rtl/fetch_ifid_stage.sv - instruction fetch stage and IF/ID pipeline register
// Tracks the PC, drives the synchronous instruction memory and absorbs stalls, redirects and flushes.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm16
);

    logic [31:0] pc_q, pc_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

    always_comb begin
        pc_d          = pc_q;
        f_valid_d     = f_valid_q;
        f_pc_d        = f_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;

        // A redirect kills the word already in flight: it came from the wrong path.
        if (branch_taken) begin
            pc_d      = branch_target & ~32'h0000_0003;
            f_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d      = pc_q + 32'd4;
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
        end

        if (flush || branch_taken) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (!stall) begin
            id_valid_d    = f_valid_q;
            id_instr_d    = f_valid_q ? imem_rdata : NOP_INSTR;
            id_pc_plus4_d = f_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            f_valid_q     <= 1'b0;
            f_pc_q        <= 32'h0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_plus4_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            f_valid_q     <= f_valid_d;
            f_pc_q        <= f_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    // Memory keeps its last word while disabled, which is what lets a stall hold the in-flight word.
    assign imem_addr   = pc_q;
    assign imem_en     = ~stall | branch_taken;

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_opcode   = id_instr_q[31:26];
    assign id_rs       = id_instr_q[25:21];
    assign id_rt       = id_instr_q[20:16];
    assign id_rd       = id_instr_q[15:11];
    assign id_imm16    = id_instr_q[15:0];

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb/tb_fetch_ifid_stage.sv - scoreboard bench for fetch_ifid_stage
module tb_fetch_ifid_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        imem_en;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm16;

    logic [31:0] w_addr, w_rdata = 32'h0;
    logic        w_en;
    logic        w_valid;
    logic [31:0] w_instr, w_pc4;
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm16;

    always #5 clk = ~clk;

    fetch_ifid_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm16(id_imm16)
    );

    fetch_ifid_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .imem_addr(w_addr), .imem_en(w_en), .imem_rdata(w_rdata),
        .id_valid(w_valid), .id_instr(w_instr), .id_pc_plus4(w_pc4),
        .id_opcode(w_opcode), .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd),
        .id_imm16(w_imm16)
    );

    // Instruction memory contents: word at byte address a is a+1.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr + 32'd1;
        if (w_en)    w_rdata    <= w_addr + 32'd1;
    end

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        cur;
    logic [31:0] flight[$];
    logic [31:0] m_pc = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t bubble();
        ent_t e;
        e.v = 1'b0; e.instr = NOP; e.pc4 = 32'h0;
        return e;
    endfunction

    // Reference model: fetched addresses queue up in program order; ID takes one per advancing edge.
    task automatic model_edge(input logic s, input logic f, input logic b, input logic [31:0] t);
        ent_t        e;
        logic [31:0] a;
        e = bubble();
        if (b) begin
            exp_q.push_back(e);
            flight.delete();
            m_pc = {t[31:2], 2'b00};
        end else if (s) begin
            if (f) exp_q.push_back(e);
        end else begin
            if (flight.size() > 0) begin
                a = flight.pop_front();
                if (!f) begin
                    e.v = 1'b1; e.instr = a + 32'd1; e.pc4 = a + 32'd4;
                end
            end
            exp_q.push_back(e);
            flight.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
        stall = s; flush = f; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_edge(s, f, b, t);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, id_valid}, 32'h0);
        chk("async_rst_instr", id_instr, NOP);
        chk("async_rst_pc4", id_pc_plus4, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        exp_q.delete();
        flight.delete();
        m_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cur = bubble();
            chk("rst_valid", {31'b0, id_valid}, 32'h0);
            chk("rst_instr", id_instr, NOP);
            chk("rst_pc4", id_pc_plus4, 32'h0);
            chk("rst_addr", imem_addr, 32'h0);
        end else begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            chk("id_valid", {31'b0, id_valid}, {31'b0, cur.v});
            chk("id_instr", id_instr, cur.instr);
            chk("id_opcode", {26'b0, id_opcode}, {26'b0, cur.instr[31:26]});
            chk("id_rs", {27'b0, id_rs}, {27'b0, cur.instr[25:21]});
            chk("id_rt", {27'b0, id_rt}, {27'b0, cur.instr[20:16]});
            chk("id_rd", {27'b0, id_rd}, {27'b0, cur.instr[15:11]});
            chk("id_imm16", {16'b0, id_imm16}, {16'b0, cur.instr[15:0]});
            if (cur.v) chk("id_pc_plus4", id_pc_plus4, cur.pc4);
            chk("imem_addr", imem_addr, m_pc);
        end
    end

    // Wrap instance: free-running from RESET_PC=FFFF_FFF8 after the first reset release.
    initial begin
        logic [31:0] e_v[4];
        logic [31:0] e_ins[4];
        logic [31:0] e_pc4[4];
        logic [31:0] e_addr[4];
        e_v    = '{32'd0, 32'd1, 32'd1, 32'd1};
        e_ins  = '{NOP, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0000_0001};
        e_pc4  = '{32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        e_addr = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        @(negedge rst);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wrap_valid", {31'b0, w_valid}, e_v[k]);
            chk("wrap_instr", w_instr, e_ins[k]);
            if (k > 0) chk("wrap_pc4", w_pc4, e_pc4[k]);
            chk("wrap_addr", w_addr, e_addr[k]);
        end
    end

    initial begin
        int r;
        logic s, f, b;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        idle(4);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0042);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            s = (r < 25);
            f = ($urandom_range(9) == 0);
            b = ($urandom_range(9) == 0);
            step(s, f, b, $urandom);
        end

        do_reset();
        idle(6);

        for (int i = 0; i < 200; i++) begin
            s = ($urandom_range(3) == 0);
            f = ($urandom_range(7) == 0);
            b = ($urandom_range(7) == 0);
            step(s, f, b, $urandom);
        end

        idle(2);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
